modbus_rtu_rx_frame: RTL and testbench



---
 rtl/modbus_rtu_rx_frame.sv | 145 ++++++++++++++
 tb/tb_modbus_rtu_rx_frame.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/modbus_rtu_rx_frame.sv
// Modbus RTU receive-frame buffer: collects bytes between frame strobes, checks CRC-16/Modbus,
// filters by slave address and holds an accepted frame for random-access reads until acknowledged.
module modbus_rtu_rx_frame #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    slave_id,
  input  logic          bcast_en,
  input  logic [7:0]    rx_data_i,
  input  logic          rx_valid_i,
  input  logic          frame_start_i,
  input  logic          frame_end_i,
  output logic          frm_valid_o,
  output logic [AW:0]   frm_len_o,
  output logic          frm_bcast_o,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o,
  input  logic          frm_ack_i,
  output logic          crc_err_o,
  output logic          len_err_o,
  output logic          drop_o
);

  typedef enum logic [2:0] {IDLE, RECV, CHECK, HOLD, DROP} state_t;

  localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0] MIN_LEN = (AW+1)'(4);

  state_t      state;
  logic [7:0]  mem [DEPTH];
  logic [AW:0] wptr;
  logic [15:0] crc;
  logic        ovf;
  logic        ack_seen;
  logic [7:0]  addr_byte;

  logic        restart;
  logic        byte_in;
  logic        mem_we;
  logic [AW:0] wr_idx;
  logic [15:0] crc_next;

  // Reflected CRC-16/Modbus update by one byte (polynomial 0x8005 -> 0xA001).
  function automatic logic [15:0] crc16_byte(input logic [15:0] c_in, input logic [7:0] b);
    logic [15:0] c;
    c = c_in ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  // A start strobe may carry the first byte in the same cycle, so restart and store are merged.
  assign restart  = frame_start_i && (state == IDLE || state == RECV);
  assign byte_in  = rx_valid_i && (restart || state == RECV);
  assign wr_idx   = restart ? '0 : wptr;
  assign mem_we   = byte_in && (wr_idx < FULL);
  assign crc_next = crc16_byte(restart ? 16'hFFFF : crc, rx_data_i);

  // NOTE: the frame buffer has no reset; its contents are only meaningful below frm_len_o.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_idx[AW-1:0]] <= rx_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wptr        <= '0;
      crc         <= 16'hFFFF;
      ovf         <= 1'b0;
      ack_seen    <= 1'b0;
      addr_byte   <= 8'h00;
      frm_valid_o <= 1'b0;
      frm_len_o   <= '0;
      frm_bcast_o <= 1'b0;
      rd_data_o   <= 8'h00;
      crc_err_o   <= 1'b0;
      len_err_o   <= 1'b0;
      drop_o      <= 1'b0;
    end else begin
      crc_err_o <= 1'b0;
      len_err_o <= 1'b0;
      drop_o    <= 1'b0;

      if (state == HOLD || state == DROP) rd_data_o <= mem[rd_addr_i];

      if (restart) begin
        state <= RECV;
        ovf   <= 1'b0;
        wptr  <= byte_in ? (AW+1)'(1) : '0;
        crc   <= byte_in ? crc_next : 16'hFFFF;
        if (byte_in) addr_byte <= rx_data_i;
      end else begin
        case (state)
          RECV: begin
            if (byte_in) begin
              crc <= crc_next;
              if (mem_we) wptr <= wptr + (AW+1)'(1);
              else        ovf  <= 1'b1;
              if (wptr == '0) addr_byte <= rx_data_i;
            end
            if (frame_end_i) state <= CHECK;
          end
          CHECK: begin
            state <= IDLE;
            if (ovf || wptr < MIN_LEN) begin
              len_err_o <= 1'b1;
            end else if (crc != 16'h0000) begin
              crc_err_o <= 1'b1;
            end else if (addr_byte == slave_id || (addr_byte == 8'h00 && bcast_en)) begin
              state       <= HOLD;
              frm_valid_o <= 1'b1;
              frm_len_o   <= wptr;
              frm_bcast_o <= (addr_byte == 8'h00);
            end
          end
          HOLD: begin
            if (frm_ack_i) begin
              state       <= IDLE;
              frm_valid_o <= 1'b0;
            end else if (frame_start_i) begin
              state    <= DROP;
              ack_seen <= 1'b0;
            end
          end
          DROP: begin
            // An ack here releases the buffer at once; the dropped frame still runs to its end.
            if (frm_ack_i) begin
              ack_seen    <= 1'b1;
              frm_valid_o <= 1'b0;
            end
            if (frame_end_i) begin
              drop_o <= 1'b1;
              state  <= (ack_seen || frm_ack_i) ? IDLE : HOLD;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_modbus_rtu_rx_frame.sv
// Directed self-checking bench for modbus_rtu_rx_frame: valid, CRC, address, length,
// broadcast, drop-while-held and mid-frame reset scenarios.
module tb_modbus_rtu_rx_frame;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk;
  logic          rst;
  logic [7:0]    slave_id;
  logic          bcast_en;
  logic [7:0]    rx_data_i;
  logic          rx_valid_i;
  logic          frame_start_i;
  logic          frame_end_i;
  logic          frm_valid_o;
  logic [AW:0]   frm_len_o;
  logic          frm_bcast_o;
  logic [AW-1:0] rd_addr_i;
  logic [7:0]    rd_data_o;
  logic          frm_ack_i;
  logic          crc_err_o;
  logic          len_err_o;
  logic          drop_o;

  modbus_rtu_rx_frame #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .slave_id(slave_id), .bcast_en(bcast_en),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .frame_start_i(frame_start_i), .frame_end_i(frame_end_i),
    .frm_valid_o(frm_valid_o), .frm_len_o(frm_len_o), .frm_bcast_o(frm_bcast_o),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .frm_ack_i(frm_ack_i),
    .crc_err_o(crc_err_o), .len_err_o(len_err_o), .drop_o(drop_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0]  tx [$];
  logic [7:0]  held [$];
  logic [15:0] crc_val;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bitwise LSB-first CRC-16/Modbus over the bytes in tx.
  function automatic logic [15:0] crc_model();
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    foreach (tx[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ tx[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    end
    return c;
  endfunction

  // Sends tx back to back; returns right after the edge that samples frame_end_i.
  task automatic send_frame(input bit end_with_last);
    for (int i = 0; i < tx.size(); i++) begin
      rx_data_i     = tx[i];
      rx_valid_i    = 1'b1;
      frame_start_i = (i == 0);
      frame_end_i   = end_with_last && (i == tx.size() - 1);
      step();
    end
    rx_valid_i    = 1'b0;
    frame_start_i = 1'b0;
    frame_end_i   = 1'b0;
    if (!end_with_last) begin
      frame_end_i = 1'b1;
      step();
      frame_end_i = 1'b0;
    end
  endtask

  task automatic read_check(input string tag, input int addr, input logic [31:0] exp);
    rd_addr_i = addr[AW-1:0];
    step();
    check(tag, 32'(rd_data_o), exp);
  endtask

  task automatic ack();
    frm_ack_i = 1'b1;
    step();
    frm_ack_i = 1'b0;
    check("valid_after_ack", 32'(frm_valid_o), 0);
  endtask

  initial begin
    rst = 1'b1; slave_id = 8'h01; bcast_en = 1'b0;
    rx_data_i = 8'h00; rx_valid_i = 1'b0; frame_start_i = 1'b0; frame_end_i = 1'b0;
    rd_addr_i = '0; frm_ack_i = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("reset_valid", 32'(frm_valid_o), 0);
    check("reset_len",   32'(frm_len_o),   0);
    check("reset_bcast", 32'(frm_bcast_o), 0);
    check("reset_rd",    32'(rd_data_o),   0);
    check("reset_pulses", {29'd0, crc_err_o, len_err_o, drop_o}, 0);

    // Valid unicast frame
    tx = '{8'h01, 8'h05, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h8C, 8'h3A};
    send_frame(1'b0);
    check("valid_at_n1", 32'(frm_valid_o), 0);
    step();
    check("valid_at_n2", 32'(frm_valid_o), 1);
    check("len_valid",   32'(frm_len_o),   8);
    check("bcast_uni",   32'(frm_bcast_o), 0);
    check("crc_err_ok",  32'(crc_err_o),   0);
    for (int i = 0; i < 8; i++) read_check("rd_frame_a", i, 32'(tx[i]));
    ack();

    // Corrupted CRC
    tx[7] = 8'h3B;
    send_frame(1'b0);
    step();
    check("crc_err_pulse", 32'(crc_err_o),   1);
    check("crc_err_novld", 32'(frm_valid_o), 0);
    step();
    check("crc_err_width", 32'(crc_err_o),   0);

    // Address filtered out silently
    tx[7] = 8'h3A;
    slave_id = 8'h02;
    send_frame(1'b0);
    step();
    check("addr_no_crc", 32'(crc_err_o),   0);
    check("addr_no_len", 32'(len_err_o),   0);
    check("addr_novld",  32'(frm_valid_o), 0);
    step();
    check("addr_novld2", 32'(frm_valid_o), 0);

    // Broadcast accepted and held
    bcast_en = 1'b1;
    tx = '{8'h00, 8'h05, 8'h00, 8'h00, 8'hFF, 8'h00};
    crc_val = crc_model();
    tx.push_back(crc_val[7:0]);
    tx.push_back(crc_val[15:8]);
    send_frame(1'b0);
    step();
    check("bcast_valid", 32'(frm_valid_o), 1);
    check("bcast_flag",  32'(frm_bcast_o), 1);
    check("bcast_len",   32'(frm_len_o),   8);
    held = tx;

    // Second frame while held is dropped; buffer untouched
    tx = '{8'h01, 8'h05, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h8C, 8'h3A};
    send_frame(1'b0);
    check("drop_pulse",  32'(drop_o),      1);
    check("drop_valid",  32'(frm_valid_o), 1);
    step();
    check("drop_width",  32'(drop_o),      0);
    check("drop_no_crc", 32'(crc_err_o),   0);
    read_check("rd_held_0", 0, 32'(held[0]));
    read_check("rd_held_6", 6, 32'(held[6]));
    read_check("rd_held_7", 7, 32'(held[7]));
    check("drop_len_kept", 32'(frm_len_o), 8);
    ack();

    // Too short
    tx = '{8'h01, 8'h05, 8'h00};
    send_frame(1'b0);
    step();
    check("short_len_err", 32'(len_err_o), 1);
    step();
    check("short_width",   32'(len_err_o), 0);

    // Too long: DEPTH+1 bytes, byte i = i mod 256
    tx.delete();
    for (int i = 0; i < DEPTH + 1; i++) tx.push_back(i[7:0]);
    send_frame(1'b0);
    step();
    check("long_len_err", 32'(len_err_o),   1);
    check("long_novld",   32'(frm_valid_o), 0);
    slave_id = 8'h01;
    tx = '{8'h01, 8'h05, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h8C, 8'h3A};
    send_frame(1'b0);
    step();
    check("after_long_vld", 32'(frm_valid_o), 1);
    read_check("stale_8",   8,   'h08);
    read_check("new_3",     3,   'h00);
    read_check("stale_255", 255, 'hFF);
    ack();

    // Reset after 4 bytes of a frame
    for (int i = 0; i < 4; i++) begin
      rx_data_i = tx[i]; rx_valid_i = 1'b1; frame_start_i = (i == 0);
      step();
    end
    rx_valid_i = 1'b0; frame_start_i = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_valid", 32'(frm_valid_o), 0);
    check("mrst_len",   32'(frm_len_o),   0);
    check("mrst_rd",    32'(rd_data_o),   0);
    frame_end_i = 1'b1;
    step();
    frame_end_i = 1'b0;
    step();
    check("mrst_no_pulse", {29'd0, crc_err_o, len_err_o, drop_o}, 0);

    // Valid frame whose last byte coincides with frame_end
    send_frame(1'b1);
    check("joint_end_n1", 32'(frm_valid_o), 0);
    step();
    check("joint_end_vld", 32'(frm_valid_o), 1);
    check("joint_end_len", 32'(frm_len_o),   8);
    read_check("joint_rd_7", 7, 'h3A);
    ack();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
